mem_responder: RTL and testbench

- Memory-side responder for the multicycle ARMv4 core's unified instruction/data port.
- Accepts one read or write request at a time through a valid/ready handshake.
- Inserts a configurable number of wait states, then returns a one-cycle response pulse carrying read data and an error flag.
- Sits between the datapath's address/write-data mux and the word-addressed storage, in place of a zero-latency combinational memory.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_array.sv | 32 +++
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
//   state_e    : responder FSM states (encoding fixed here)
//   WORD_BYTES : bytes per storage word
//   clog2      : index width for a given word count
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Smallest r with 2**r >= n.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    logic [32:0] v;
    r = 0;
    v = 33'd1;
    for (int i = 0; i < 32; i++) begin
      if (v < {1'b0, n}) begin
        v = v << 1;
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage for the memory responder.
//   clk   : write clock
//   we    : write enable, sampled on the rising edge
//   index : word index shared by the read and write ports
//   wdata : write data
//   rdata : combinational read of the word at index
// Contents are not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IDX_W       = clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the unified instruction/data port.
// Accepts one request at a time, waits LATENCY cycles, then emits a one-cycle
// response carrying read data and an error flag.
//   clk, reset                    : clock, asynchronous active-high reset
//   req_valid/req_ready           : request handshake (accept on valid & ready)
//   req_we, req_addr, req_wdata   : request; captured at acceptance
//   resp_valid                    : one-cycle response pulse
//   resp_rdata, resp_err          : response payload, zero while resp_valid=0
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IdxW       = clog2(DEPTH_WORDS);
  localparam int unsigned OffW       = clog2(WORD_BYTES);
  localparam logic [3:0]  CntInit    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [31:0] DepthLimit = 32'(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              err;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = req_valid & req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY > 0) begin
            state_d = StWait;
            cnt_d   = CntInit;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request is frozen at acceptance; the port is ignored until the next IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Out-of-range indices are errors rather than aliases of low words.
  assign err = (addr_q[OffW-1:0] != '0) || ((addr_q >> OffW) >= DepthLimit);

  // Write lands on the edge that ends RESP, so a same-cycle read sees old data.
  assign arr_we = resp_valid & we_q & ~err;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_W     (DATA_W),
    .IDX_W      (IdxW)
  ) u_mem_array (
    .clk  (clk),
    .we   (arr_we),
    .index(addr_q[OffW +: IdxW]),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  assign resp_rdata = (resp_valid && !we_q && !err) ? arr_rdata : '0;
  assign resp_err   = resp_valid & err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 instance (a_*) and a LATENCY=0
// instance (b_*), both DEPTH_WORDS=64. Expected responses go into a scoreboard
// queue when a request is driven and are popped when resp_valid appears.
module tb_mem_responder;

  logic clk;
  logic reset;

  logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  logic        use_b;
  logic        obs_ready, obs_resp, obs_err;
  logic [31:0] obs_rdata;

  assign obs_ready = use_b ? b_req_ready  : a_req_ready;
  assign obs_resp  = use_b ? b_resp_valid : a_resp_valid;
  assign obs_err   = use_b ? b_resp_err   : a_resp_err;
  assign obs_rdata = use_b ? b_resp_rdata : a_resp_rdata;

  mem_responder #(
    .DEPTH_WORDS(64),
    .LATENCY    (2),
    .DATA_W     (32)
  ) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_we    (a_req_we),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata),
    .resp_err  (a_resp_err)
  );

  mem_responder #(
    .DEPTH_WORDS(64),
    .LATENCY    (0),
    .DATA_W     (32)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata),
    .resp_err  (b_resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  int n_pass  = 0;
  int n_total = 0;
  logic [32:0] sb[$];  // {err, rdata}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    if (use_b) begin
      b_req_valid = v; b_req_we = we; b_req_addr = a; b_req_wdata = d;
    end else begin
      a_req_valid = v; a_req_we = we; a_req_addr = a; a_req_wdata = d;
    end
  endtask

  task automatic check_resp(input string tag);
    logic [32:0] e;
    check({tag, "_resp_expected"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, obs_rdata, e[31:0]);
      check({tag, "_err"}, 32'(obs_err), 32'(e[32]));
    end
  endtask

  // One transaction; starts and ends at a falling edge with the DUT idle.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input logic exp_err);
    int cyc;
    int lat;
    lat = use_b ? 0 : 2;
    drive(1'b1, we, addr, wdata);
    cyc = 0;
    while (!obs_ready && cyc < 32) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_ready"}, 32'(obs_ready), 1);
    sb.push_back({exp_err, exp_rd});
    @(negedge clk);
    // Scramble the port after acceptance; the captured request must win.
    drive(1'b0, 1'($urandom), $urandom, $urandom);
    cyc = 1;
    while (!obs_resp && cyc < 32) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, lat + 1);
    check_resp(tag);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(obs_resp), 0);
  endtask

  // req_valid held high; reads alternate a0/a1 and must land every LATENCY+2 cycles.
  task automatic burst(input string tag, input int ncyc, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    int per;
    int k;
    per = use_b ? 2 : 4;
    k = 0;
    for (int i = 0; i < ncyc; i++) begin
      check({tag, "_ready"}, 32'(obs_ready), 32'(i % per == 0));
      check({tag, "_resp"}, 32'(obs_resp), 32'(i % per == per - 1));
      if (obs_resp) check_resp(tag);
      if (obs_ready) begin
        drive(1'b1, 1'b0, (k % 2 == 0) ? a0 : a1, $urandom);
        sb.push_back({1'b0, (k % 2 == 0) ? d0 : d1});
        k++;
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    check({tag, "_drained"}, 32'(sb.size()), 0);
  endtask

  logic seen;

  initial begin
    reset = 1'b1;
    use_b = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;

    #12;
    check("rst_ready", 32'(a_req_ready), 1);
    check("rst_resp_valid", 32'(a_resp_valid), 0);
    check("rst_rdata", a_resp_rdata, 0);
    check("rst_err", 32'(a_resp_err), 0);
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_ready", 32'(a_req_ready), 1);

    // Write then read back
    txn("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("rd10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Error cases leave the array untouched
    txn("wr00", 1'b1, 32'h0, 32'h11111111, 32'h0, 1'b0);
    txn("wr12_mis", 1'b1, 32'h12, 32'h0BADF00D, 32'h0, 1'b1);
    txn("wr100_oor", 1'b1, 32'h100, 32'h0BAD0000, 32'h0, 1'b1);
    txn("rd100_oor", 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    txn("rd13_mis", 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    txn("rd10_after_err", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    txn("rd00_after_oor", 1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0);

    // Handshake with req_valid held high
    burst("a_burst", 12, 32'h10, 32'h0, 32'hDEADBEEF, 32'h11111111);

    // Inputs scrambled during WAIT must not affect the captured request
    txn("wr28", 1'b1, 32'h28, 32'hCAFEF00D, 32'h0, 1'b0);
    txn("rd28", 1'b0, 32'h28, 32'h0, 32'hCAFEF00D, 1'b0);
    txn("rd10_stable", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset in WAIT discards the pending write
    txn("wr20", 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("rst_mid_in_wait", 32'(a_req_ready), 0);
    reset = 1'b1;
    #1;
    check("rst_mid_async_ready", 32'(a_req_ready), 1);
    seen = a_resp_valid;
    repeat (2) begin
      @(negedge clk);
      seen = seen | a_resp_valid;
    end
    reset = 1'b0;
    check("rst_mid_ready_after", 32'(a_req_ready), 1);
    repeat (4) begin
      @(negedge clk);
      seen = seen | a_resp_valid;
    end
    check("rst_mid_no_resp", 32'(seen), 0);
    txn("rd20_old", 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

    // LATENCY=0 instance
    use_b = 1'b1;
    txn("b_wr0", 1'b1, 32'h0, 32'h0000AAAA, 32'h0, 1'b0);
    txn("b_wr4", 1'b1, 32'h4, 32'h5555BBBB, 32'h0, 1'b0);
    txn("b_rd4", 1'b0, 32'h4, 32'h0, 32'h5555BBBB, 1'b0);
    txn("b_wr100_oor", 1'b1, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
    burst("b_burst", 8, 32'h0, 32'h4, 32'h0000AAAA, 32'h5555BBBB);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
